// File: rtl/ifm_wgt_feeder_pkg.sv
// Shared FSM encoding, default layer geometry and elaboration-time size helpers
// for the ifm/weight feeder.
package ifm_wgt_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RUN      = 3'd2,
    S_WAIT_END = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Geometry of the default configuration (28x28, K=5, PAD=2, CI=3, CO=8).
  localparam int PADDED    = 28 + 2 * 2;
  localparam int WGT_TOTAL = 8 * 3 * 5 * 5;
  localparam int IFM_TOTAL = 8 * 3 * PADDED * PADDED;

  function automatic int padded_side(input int ifm_size, input int pad);
    return ifm_size + 2 * pad;
  endfunction

  function automatic int wgt_words(input int co, input int ci, input int k);
    return co * ci * k * k;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ifm_wgt_feeder_pad_raster_counter.sv
// Walks one full padded ifm (channel, row, column), flags border positions and
// keeps the interior memory address as a running count.
module pad_raster_counter
  import ifm_wgt_feeder_pkg::*;
#(
  parameter int IFM_SIZE   = 28,
  parameter int PAD        = 2,
  parameter int CI         = 3,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  last_pass,
  output logic                  pad,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap,
  output logic                  last
);

  localparam int SIDE = padded_side(IFM_SIZE, PAD);
  localparam int XW   = cnt_width(SIDE);
  localparam int CW   = cnt_width(CI);

  logic [XW-1:0]         x;
  logic [XW-1:0]         y;
  logic [CW-1:0]         ci;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  x_end;
  logic                  y_end;
  logic                  ci_end;

  assign x_end  = (x == XW'(SIDE - 1));
  assign y_end  = (y == XW'(SIDE - 1));
  assign ci_end = (ci == CW'(CI - 1));
  assign wrap   = x_end && y_end && ci_end;
  assign last   = wrap && last_pass;
  assign pad    = (int'(x) < PAD) || (int'(x) >= IFM_SIZE + PAD) ||
                  (int'(y) < PAD) || (int'(y) >= IFM_SIZE + PAD);
  assign addr   = addr_q;

  // Interior words are contiguous in memory in raster order, so the address
  // just counts interior positions and restarts when the ifm is replayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      ci     <= '0;
      addr_q <= '0;
    end else if (clear) begin
      x      <= '0;
      y      <= '0;
      ci     <= '0;
      addr_q <= '0;
    end else if (step) begin
      if (wrap) addr_q <= '0;
      else if (!pad) addr_q <= addr_q + 1'b1;
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) begin
        y <= y_end ? '0 : y + 1'b1;
        if (y_end) ci <= ci_end ? '0 : ci + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifm_wgt_feeder.sv
// Feeds weight and zero-padded ifm words from two read-latency-1 memories to a
// convolution accelerator that pulls each stream with its own read strobe.
module ifm_wgt_feeder #(
  parameter int IFM_WIDTH    = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int IFM_SIZE     = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int PAD          = 2,
  parameter int CI           = 3,
  parameter int CO           = 8,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    start_conv,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  input  logic                    end_conv,
  output logic [IFM_WIDTH-1:0]    ifm,
  output logic [WEIGHT_WIDTH-1:0] wgt,
  output logic                    ifm_mem_en,
  output logic [ADDR_WIDTH-1:0]   ifm_mem_addr,
  input  logic [IFM_WIDTH-1:0]    ifm_mem_rdata,
  output logic                    wgt_mem_en,
  output logic [ADDR_WIDTH-1:0]   wgt_mem_addr,
  input  logic [WEIGHT_WIDTH-1:0] wgt_mem_rdata
);

  import ifm_wgt_feeder_pkg::*;

  localparam int WGT_WORDS = wgt_words(CO, CI, KERNEL_SIZE);
  localparam int WW        = cnt_width(WGT_WORDS + 1);
  localparam int PW        = cnt_width(CO);

  state_t                state;
  state_t                next_state;
  logic                  early_end;
  logic [WW-1:0]         wgt_cnt;
  logic [PW-1:0]         pass_cnt;
  logic                  pass_end;
  logic                  wgt_exh;
  logic                  ifm_exh;
  logic                  streaming;
  logic                  accept;
  logic                  ifm_serve;
  logic                  ifm_bad;
  logic                  wgt_serve;
  logic                  wgt_bad;
  logic                  pad_q;
  logic                  zero_q;
  logic                  raster_pad;
  logic [ADDR_WIDTH-1:0] raster_addr;
  logic                  raster_wrap;
  logic                  raster_last;

  // Strobe contract: each ifm_read/wgt_read high for one cycle in RUN consumes
  // exactly one word; its memory access is issued in that same cycle and the
  // word is presented on ifm/wgt from the next cycle until the next strobe.
  assign streaming  = (state == S_RUN) || (state == S_WAIT_END);
  assign accept     = (state == S_IDLE) && start;
  assign wgt_exh    = (wgt_cnt == WW'(WGT_WORDS));
  assign pass_end   = (pass_cnt == PW'(CO - 1));
  assign ifm_serve  = ifm_read && streaming && !ifm_exh;
  assign ifm_bad    = ifm_read && !ifm_serve;
  assign wgt_serve  = wgt_read && streaming && !wgt_exh;
  assign wgt_bad    = wgt_read && !wgt_serve;

  assign ifm_mem_en   = ifm_serve && !raster_pad;
  assign ifm_mem_addr = ifm_mem_en ? raster_addr : '0;
  assign wgt_mem_en   = wgt_serve;
  assign wgt_mem_addr = wgt_serve ? ADDR_WIDTH'(wgt_cnt) : '0;
  assign ifm          = pad_q ? '0 : ifm_mem_rdata;
  assign wgt          = zero_q ? '0 : wgt_mem_rdata;

  assign busy       = (state == S_START) || (state == S_RUN) || (state == S_WAIT_END);
  assign start_conv = (state == S_START);
  assign done       = (state == S_DONE);

  pad_raster_counter #(
    .IFM_SIZE  (IFM_SIZE),
    .PAD       (PAD),
    .CI        (CI),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .step     (ifm_serve),
    .last_pass(pass_end),
    .pad      (raster_pad),
    .addr     (raster_addr),
    .wrap     (raster_wrap),
    .last     (raster_last)
  );

  always_comb begin
    next_state = state;
    early_end  = 1'b0;
    case (state)
      S_IDLE:     if (start) next_state = S_START;
      S_START:    next_state = S_RUN;
      S_RUN: begin
        if (end_conv) begin
          next_state = S_DONE;
          early_end  = !(ifm_exh && wgt_exh);
        end else if (ifm_exh && wgt_exh) begin
          next_state = S_WAIT_END;
        end
      end
      S_WAIT_END: if (end_conv) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wgt_cnt  <= '0;
      pass_cnt <= '0;
      ifm_exh  <= 1'b0;
      pad_q    <= 1'b1;
      zero_q   <= 1'b1;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      err   <= (accept ? 1'b0 : err) | ifm_bad | wgt_bad | early_end;
      if (accept) begin
        wgt_cnt  <= '0;
        pass_cnt <= '0;
        ifm_exh  <= 1'b0;
        pad_q    <= 1'b1;
        zero_q   <= 1'b1;
      end else begin
        if (wgt_serve) wgt_cnt <= wgt_cnt + 1'b1;
        if (ifm_serve && raster_wrap) pass_cnt <= pass_end ? '0 : pass_cnt + 1'b1;
        if (ifm_serve && raster_last) ifm_exh <= 1'b1;
        if (ifm_serve) pad_q <= raster_pad;
        else if (ifm_bad) pad_q <= 1'b1;
        if (wgt_serve) zero_q <= 1'b0;
        else if (wgt_bad) zero_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifm_wgt_feeder.sv
// Directed bench for ifm_wgt_feeder on a 4x4 ifm, K=3, PAD=1, CI=2, CO=2 layer
// with behavioural read-latency-1 memories and expected-word queues.
module tb_ifm_wgt_feeder;

  localparam int IFM_SIZE = 4;
  localparam int K        = 3;
  localparam int PAD      = 1;
  localparam int CI       = 2;
  localparam int CO       = 2;
  localparam int SIDE     = IFM_SIZE + 2 * PAD;
  localparam int WGT_N    = CO * CI * K * K;
  localparam int IFM_N    = CO * CI * SIDE * SIDE;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        start_conv;
  logic        ifm_read;
  logic        wgt_read;
  logic        end_conv;
  logic [15:0] ifm;
  logic [15:0] wgt;
  logic        ifm_mem_en;
  logic [15:0] ifm_mem_addr;
  logic [15:0] ifm_mem_rdata;
  logic        wgt_mem_en;
  logic [15:0] wgt_mem_addr;
  logic [15:0] wgt_mem_rdata;

  logic [15:0] ifm_q[$];
  logic [15:0] wgt_q[$];
  int          vectors;
  int          miscompares;
  int          ifm_idx;
  int          wgt_idx;
  int          pad_seen;
  bit          running;

  ifm_wgt_feeder #(
    .IFM_WIDTH   (16),
    .WEIGHT_WIDTH(16),
    .IFM_SIZE    (IFM_SIZE),
    .KERNEL_SIZE (K),
    .PAD         (PAD),
    .CI          (CI),
    .CO          (CO),
    .ADDR_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .start_conv   (start_conv),
    .ifm_read     (ifm_read),
    .wgt_read     (wgt_read),
    .end_conv     (end_conv),
    .ifm          (ifm),
    .wgt          (wgt),
    .ifm_mem_en   (ifm_mem_en),
    .ifm_mem_addr (ifm_mem_addr),
    .ifm_mem_rdata(ifm_mem_rdata),
    .wgt_mem_en   (wgt_mem_en),
    .wgt_mem_addr (wgt_mem_addr),
    .wgt_mem_rdata(wgt_mem_rdata)
  );

  // clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // memories: ifm word = addr+500, weight word = addr+100
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_mem_rdata <= 16'd0;
      wgt_mem_rdata <= 16'd0;
    end else begin
      if (ifm_mem_en) ifm_mem_rdata <= ifm_mem_addr + 16'd500;
      if (wgt_mem_en) wgt_mem_rdata <= wgt_mem_addr + 16'd100;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ifm_model(input int idx, output logic p, output logic [15:0] a);
    int pos, ci, x, y;
    pos = idx % (SIDE * SIDE);
    ci  = (idx / (SIDE * SIDE)) % CI;
    y   = pos / SIDE;
    x   = pos % SIDE;
    p   = (x < PAD) || (x >= IFM_SIZE + PAD) || (y < PAD) || (y >= IFM_SIZE + PAD);
    a   = p ? 16'd0 : 16'(ci * IFM_SIZE * IFM_SIZE + (y - PAD) * IFM_SIZE + (x - PAD));
  endfunction

  // One clock: drive strobes at a falling edge, check the combinational memory
  // request, then check the delivered words at the next falling edge.
  task automatic step(input logic ir, input logic wr);
    logic        p;
    logic [15:0] a;
    ifm_read = ir;
    wgt_read = wr;
    #1;
    if (ir && running && ifm_idx < IFM_N) begin
      ifm_model(ifm_idx, p, a);
      chk1("ifm_mem_en", ifm_mem_en, ~p);
      if (!p) chk16("ifm_mem_addr", ifm_mem_addr, a);
      ifm_q.push_back(p ? 16'd0 : a + 16'd500);
      ifm_idx++;
    end else begin
      chk1("ifm_mem_en_off", ifm_mem_en, 1'b0);
      if (ir) ifm_q.push_back(16'd0);
    end
    if (ir && !ifm_mem_en) pad_seen++;
    if (wr && running && wgt_idx < WGT_N) begin
      chk1("wgt_mem_en", wgt_mem_en, 1'b1);
      chk16("wgt_mem_addr", wgt_mem_addr, 16'(wgt_idx));
      wgt_q.push_back(16'(wgt_idx + 100));
      wgt_idx++;
    end else begin
      chk1("wgt_mem_en_off", wgt_mem_en, 1'b0);
      if (wr) wgt_q.push_back(16'd0);
    end
    @(negedge clk);
    ifm_read = 1'b0;
    wgt_read = 1'b0;
    if (ir) chk16("ifm_word", ifm, ifm_q.pop_front());
    if (wr) chk16("wgt_word", wgt, wgt_q.pop_front());
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("start_conv_pulse", start_conv, 1'b1);
    chk1("busy_in_start", busy, 1'b1);
    chk1("err_cleared_by_start", err, 1'b0);
    ifm_idx = 0;
    wgt_idx = 0;
    running = 1'b1;
    @(negedge clk);
    chk1("start_conv_low", start_conv, 1'b0);
    chk1("busy_in_run", busy, 1'b1);
  endtask

  task automatic do_end(input logic exp_err);
    end_conv = 1'b1;
    @(negedge clk);
    end_conv = 1'b0;
    running  = 1'b0;
    chk1("done_pulse", done, 1'b1);
    chk1("err_at_done", err, exp_err);
    chk1("busy_at_done", busy, 1'b0);
    @(negedge clk);
    chk1("done_low", done, 1'b0);
    chk1("busy_idle", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_start_conv"}, start_conv, 1'b0);
    chk16({tag, "_ifm"}, ifm, 16'd0);
    chk16({tag, "_wgt"}, wgt, 16'd0);
    chk1({tag, "_ifm_mem_en"}, ifm_mem_en, 1'b0);
    chk1({tag, "_wgt_mem_en"}, wgt_mem_en, 1'b0);
    chk16({tag, "_ifm_mem_addr"}, ifm_mem_addr, 16'd0);
    chk16({tag, "_wgt_mem_addr"}, wgt_mem_addr, 16'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ifm_idx     = 0;
    wgt_idx     = 0;
    pad_seen    = 0;
    running     = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    ifm_read    = 1'b0;
    wgt_read    = 1'b0;
    end_conv    = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // strobe while idle: ignored, output zero, sticky err
    step(1'b1, 1'b0);
    chk1("err_idle_strobe", err, 1'b1);
    chk1("busy_idle_strobe", busy, 1'b0);

    // layer A: all weights, then the whole padded ifm back to back
    do_start();
    for (int i = 0; i < WGT_N; i++) step(1'b0, 1'b1);
    pad_seen = 0;
    for (int i = 0; i < IFM_N; i++) step(1'b1, 1'b0);
    chk16("pad_words_total", 16'(pad_seen), 16'd80);
    chk16("wgt_holds_last", wgt, 16'd135);
    chk1("err_clean_layer", err, 1'b0);
    chk1("busy_wait_end", busy, 1'b1);
    step(1'b0, 1'b1);
    chk1("err_extra_wgt", err, 1'b1);
    do_end(1'b1);

    // layer B: both strobes every cycle while weights last
    do_start();
    for (int i = 0; i < WGT_N; i++) step(1'b1, 1'b1);
    for (int i = WGT_N; i < IFM_N; i++) step(1'b1, 1'b0);
    chk1("err_dual_layer", err, 1'b0);
    chk1("busy_dual_wait", busy, 1'b1);
    do_end(1'b0);

    // layer C: accelerator ends early
    do_start();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk1("err_before_early_end", err, 1'b0);
    do_end(1'b1);

    // layer D: reset in the middle of RUN
    do_start();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    #3;
    rst     = 1'b1;
    running = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("no_done_in_reset", done, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("no_done_after_reset", done, 1'b0);
      chk1("idle_after_reset", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
